gshare_predictor_nb: RTL and testbench
======================================

Name: gshare_predictor_nb

Overview:
- Next-generation branch direction predictor: table of N-bit saturating counters, indexed by PC, optionally XOR-ed with a global history register (GHR).
- Sits in the fetch stage. The lookup result is registered (1-cycle latency).
- The execute stage returns the resolved outcome to train the table and repair the GHR on mispredict.

Parameters:
- ENTRY_NUM, 256: number of counter entries; power of two, ≥4.
- CNT_WIDTH, 2: counter width in bits, 1..4.
- GHR_WIDTH, 8: global history length, 1..AW.
- MODE, 1: 0 = bimodal (history ignored), 1 = gshare.
- PC_LSB, 2: lowest PC bit used for indexing.
- AW, $clog2(ENTRY_NUM): index width; derived, never overridden.

Ports:
- cpu_clk  in  1  core clock
- cpu_rstn  in  1  async active-low reset
- pred_req  in  1  lookup request this cycle
- pred_pc  in  32  PC of the looked-up branch
- pred_valid  out  1  registered prediction valid
- pred_taken  out  1  predicted direction
- pred_cnt  out  CNT_WIDTH  counter value used for the prediction
- pred_ghr  out  GHR_WIDTH  GHR snapshot used for the index; carried down the pipe
- upd_valid  in  1  resolved branch from execute
- upd_pc  in  32  PC of the resolved branch
- upd_ghr  in  GHR_WIDTH  pred_ghr that travelled with this branch
- upd_taken  in  1  actual outcome
- upd_mispredict  in  1  direction mispredicted; qualified by upd_valid

Behaviour:
Clock and reset:
- One clock, cpu_clk. Reset cpu_rstn is asynchronous, active-low.
- On reset:
  - every counter = INIT = 2^(CNT_WIDTH-1)-1 (weakly not-taken; 2'b01 at default).
  - GHR = 0.
  - pred_valid = 0, pred_taken = 0, pred_cnt = 0, pred_ghr = 0.
- Reset asserted mid-operation discards any in-flight lookup or update. No state survives.

Index:
- idx(pc,h) = pc[PC_LSB+AW-1:PC_LSB] ^ (MODE ? {zero-extend h to AW} : 0).

Lookup:
- When pred_req is high in cycle N, the index is idx(pred_pc, GHR).
- In cycle N+1:
  - pred_valid = 1.
  - pred_cnt = counter.
  - pred_taken = counter MSB.
  - pred_ghr = the GHR value sampled in cycle N.
- When pred_req is low, pred_valid = 0 next cycle and the other outputs hold their previous values.

Speculative GHR:
- At the end of any cycle with pred_valid = 1, GHR <= {GHR[GHR_WIDTH-2:0], pred_taken}.
- A back-to-back request in N+1 does not yet see N's prediction. This is intended, and it is consistent because pred_ghr is carried with the branch.

Update:
- When upd_valid is high, the counter at idx(upd_pc, upd_ghr) saturates +1 if upd_taken, else saturates -1.
- Saturation bounds are 0 and 2^CNT_WIDTH-1; there is no wrap.

Repair:
- When upd_valid && upd_mispredict, GHR <= {upd_ghr[GHR_WIDTH-2:0], upd_taken}.
- Repair has priority over the speculative shift in the same cycle.
- The pred_valid in that cycle still presents its prediction unchanged.

Same-cycle read/write:
- When a lookup index equals the update index in the same cycle, the lookup returns the post-update counter value (write-first bypass).

Other rules:
- MODE = 0: GHR is still maintained and exported, but never used for indexing.
- GHR_WIDTH = 1: the shift reduces to GHR <= new bit.
- upd_mispredict without upd_valid is ignored.

Decomposition:
- Shared defines file core_defines.vh holds MODE_BIMODAL = 0 and MODE_GSHARE = 1.
- The CNT_INIT formula is local to the module.
- One sub-module: bp_sat_cnt, a parametrised CNT_WIDTH saturating inc/dec next-state function.
  - Inputs: cnt, taken. Output: cnt_next.
  - Combinational; instantiated once on the update path.

Test Plan:
- Reset release, MODE=1, pred_req with pred_pc=0x0000_0F54 -> next cycle pred_valid=1, pred_cnt=2'b01, pred_taken=0, pred_ghr=0.
- Three upd_valid taken updates to pc=0x100, upd_ghr=0 -> counter goes 01→10→11→11 (saturates); a lookup at pc=0x100 with GHR=0 returns pred_taken=1, pred_cnt=2'b11.
- Four untaken updates on an entry holding 2'b11 -> 10, 01, 00, 00 (no wrap).
- MODE=1, GHR=8'h05, lookup at pc=0x100 (pc index 0x40) -> reads entry 0x45; MODE=0 under the same stimulus reads entry 0x40.
- Mispredict with upd_ghr=8'hA3, upd_taken=1, in the same cycle as pred_valid=1 -> GHR=8'h47 the following cycle (speculative shift suppressed).
- Lookup and update to the same index in the same cycle, counter 01, upd_taken=1 -> pred_cnt=2'b10 next cycle. Repeat with CNT_WIDTH=3: INIT=3'b011, saturates at 3'b111.

Source files
------------

// File: rtl/gshare_predictor_nb_pkg.sv
// Shared constants for the gshare/bimodal branch direction predictor.
package gshare_predictor_nb_pkg;

   localparam int unsigned MODE_BIMODAL = 0;
   localparam int unsigned MODE_GSHARE  = 1;

endpackage

// File: rtl/gshare_predictor_nb_sat_cnt.sv
// Saturating up/down counter next-state function used on the training path.
module bp_sat_cnt
   import gshare_predictor_nb_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 2
) (
   input  logic [CNT_WIDTH-1:0] cnt,
   input  logic                 taken,
   output logic [CNT_WIDTH-1:0] cnt_next
);

   always_comb begin
      cnt_next = cnt;
      if (taken) begin
         if (cnt != '1) cnt_next = cnt + 1'b1;
      end else begin
         if (cnt != '0) cnt_next = cnt - 1'b1;
      end
   end

endmodule

// File: rtl/gshare_predictor_nb.sv
// Branch direction predictor: saturating-counter table indexed by PC, optionally
// XOR-ed with a speculative global history that is repaired on mispredict.
module gshare_predictor_nb
   import gshare_predictor_nb_pkg::*;
#(
   parameter int unsigned ENTRY_NUM = 256,
   parameter int unsigned CNT_WIDTH = 2,
   parameter int unsigned GHR_WIDTH = 8,
   parameter int unsigned MODE      = 1,
   parameter int unsigned PC_LSB    = 2
) (
   input  logic                 cpu_clk,
   input  logic                 cpu_rstn,
   input  logic                 pred_req,
   input  logic [31:0]          pred_pc,
   output logic                 pred_valid,
   output logic                 pred_taken,
   output logic [CNT_WIDTH-1:0] pred_cnt,
   output logic [GHR_WIDTH-1:0] pred_ghr,
   input  logic                 upd_valid,
   input  logic [31:0]          upd_pc,
   input  logic [GHR_WIDTH-1:0] upd_ghr,
   input  logic                 upd_taken,
   input  logic                 upd_mispredict
);

   localparam int unsigned AW = $clog2(ENTRY_NUM);
   localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);

   logic [CNT_WIDTH-1:0] cnt_tbl [ENTRY_NUM];
   logic [GHR_WIDTH-1:0] ghr;
   logic [GHR_WIDTH-1:0] spec_ghr;
   logic [GHR_WIDTH-1:0] rep_ghr;
   logic [AW-1:0]        lk_hist;
   logic [AW-1:0]        upd_hist;
   logic [AW-1:0]        lk_idx;
   logic [AW-1:0]        upd_idx;
   logic [CNT_WIDTH-1:0] upd_cnt;
   logic [CNT_WIDTH-1:0] cnt_next;
   logic [CNT_WIDTH-1:0] rd_cnt;
   logic                 unused_bits;

   // PC bits outside the index window (and history in bimodal mode) are intentionally dropped.
   assign unused_bits = ^{pred_pc, upd_pc, upd_ghr};

   assign lk_hist  = (MODE == MODE_GSHARE) ? AW'(ghr)     : '0;
   assign upd_hist = (MODE == MODE_GSHARE) ? AW'(upd_ghr) : '0;
   assign lk_idx   = pred_pc[PC_LSB +: AW] ^ lk_hist;
   assign upd_idx  = upd_pc[PC_LSB +: AW] ^ upd_hist;
   assign upd_cnt  = cnt_tbl[upd_idx];

   bp_sat_cnt #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_sat_cnt (
      .cnt      (upd_cnt),
      .taken    (upd_taken),
      .cnt_next (cnt_next)
   );

   // Write-first: a lookup colliding with this cycle's update sees the trained value.
   always_comb begin
      rd_cnt = cnt_tbl[lk_idx];
      if (upd_valid && (upd_idx == lk_idx)) rd_cnt = cnt_next;
   end

   generate
      if (GHR_WIDTH == 1) begin : g_ghr_one
         assign spec_ghr = pred_taken;
         assign rep_ghr  = upd_taken;
      end else begin : g_ghr_shift
         assign spec_ghr = {ghr[GHR_WIDTH-2:0], pred_taken};
         assign rep_ghr  = {upd_ghr[GHR_WIDTH-2:0], upd_taken};
      end
   endgenerate

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         for (int unsigned i = 0; i < ENTRY_NUM; i++) cnt_tbl[i] <= CNT_INIT;
      end else if (upd_valid) begin
         cnt_tbl[upd_idx] <= cnt_next;
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         ghr <= '0;
      end else if (upd_valid && upd_mispredict) begin
         ghr <= rep_ghr;
      end else if (pred_valid) begin
         ghr <= spec_ghr;
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
         pred_cnt   <= '0;
         pred_ghr   <= '0;
      end else begin
         pred_valid <= pred_req;
         if (pred_req) begin
            pred_cnt   <= rd_cnt;
            pred_taken <= rd_cnt[CNT_WIDTH-1];
            pred_ghr   <= ghr;
         end
      end
   end

endmodule

// File: tb/tb_gshare_predictor_nb.sv
// Directed table-driven bench for gshare_predictor_nb (gshare, bimodal and 3-bit counter variants).
module tb_gshare_predictor_nb;

   logic        cpu_clk;
   logic        cpu_rstn;
   logic        pred_req;
   logic [31:0] pred_pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [7:0]  upd_ghr;
   logic        upd_taken;
   logic        upd_mispredict;

   logic       g_valid, g_taken;
   logic [1:0] g_cnt;
   logic [7:0] g_ghr;
   logic       b_valid, b_taken;
   logic [1:0] b_cnt;
   logic [7:0] b_ghr;
   logic       w_valid, w_taken;
   logic [2:0] w_cnt;
   logic [7:0] w_ghr;

   int n_cmp;
   int n_bad;

   gshare_predictor_nb #(.MODE(1)) u_gshare (
      .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
      .pred_req(pred_req), .pred_pc(pred_pc),
      .pred_valid(g_valid), .pred_taken(g_taken), .pred_cnt(g_cnt), .pred_ghr(g_ghr),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
      .upd_taken(upd_taken), .upd_mispredict(upd_mispredict)
   );

   gshare_predictor_nb #(.MODE(0)) u_bimodal (
      .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
      .pred_req(pred_req), .pred_pc(pred_pc),
      .pred_valid(b_valid), .pred_taken(b_taken), .pred_cnt(b_cnt), .pred_ghr(b_ghr),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
      .upd_taken(upd_taken), .upd_mispredict(upd_mispredict)
   );

   gshare_predictor_nb #(.CNT_WIDTH(3)) u_cnt3 (
      .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
      .pred_req(pred_req), .pred_pc(pred_pc),
      .pred_valid(w_valid), .pred_taken(w_taken), .pred_cnt(w_cnt), .pred_ghr(w_ghr),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
      .upd_taken(upd_taken), .upd_mispredict(upd_mispredict)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   typedef struct {
      logic        req;
      logic [31:0] pc;
      logic        uv;
      logic [31:0] upc;
      logic [7:0]  ughr;
      logic        ut;
      logic        um;
      logic        ev;
      logic        et;
      logic [1:0]  ec;
      logic [7:0]  eg;
      logic        bm;
      logic [1:0]  bc;
      logic [7:0]  bg;
   } vec_t;

   vec_t tbl [20];

   function automatic vec_t mk(input logic req, input logic [31:0] pc,
                               input logic uv, input logic [31:0] upc, input logic [7:0] ughr,
                               input logic ut, input logic um,
                               input logic ev, input logic et, input logic [1:0] ec,
                               input logic [7:0] eg);
      vec_t v;
      v.req = req; v.pc = pc; v.uv = uv; v.upc = upc; v.ughr = ughr;
      v.ut = ut; v.um = um; v.ev = ev; v.et = et; v.ec = ec; v.eg = eg;
      v.bm = 1'b0; v.bc = 2'b00; v.bg = 8'h00;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, got, exp);
      end
   endtask

   task automatic drive(input logic req, input logic [31:0] pc, input logic uv,
                        input logic [31:0] upc, input logic [7:0] ughr,
                        input logic ut, input logic um);
      pred_req = req; pred_pc = pc; upd_valid = uv; upd_pc = upc;
      upd_ghr = ughr; upd_taken = ut; upd_mispredict = um;
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic chk_g(input string name, input int idx, input logic v, input logic t,
                        input logic [1:0] c, input logic [7:0] g);
      chk({name, ".valid"}, idx, g_valid, v);
      chk({name, ".taken"}, idx, g_taken, t);
      chk({name, ".cnt"},   idx, g_cnt,   c);
      chk({name, ".ghr"},   idx, g_ghr,   g);
   endtask

   task automatic chk_w(input string name, input int idx, input logic v, input logic t,
                        input logic [2:0] c, input logic [7:0] g);
      chk({name, ".w_valid"}, idx, w_valid, v);
      chk({name, ".w_taken"}, idx, w_taken, t);
      chk({name, ".w_cnt"},   idx, w_cnt,   c);
      chk({name, ".w_ghr"},   idx, w_ghr,   g);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      pred_req = 0; pred_pc = '0; upd_valid = 0; upd_pc = '0;
      upd_ghr = '0; upd_taken = 0; upd_mispredict = 0;

      //            req pc        uv upc       ughr   ut um   ev et ec     eg
      tbl[0]  = mk(1, 32'h0F54, 0, 32'h000, 8'h00, 0, 0,  1, 0, 2'b01, 8'h00);
      tbl[1]  = mk(0, 32'h0000, 0, 32'h000, 8'h00, 0, 0,  0, 0, 2'b01, 8'h00);
      tbl[2]  = mk(0, 32'h0000, 1, 32'h100, 8'h00, 1, 0,  0, 0, 2'b01, 8'h00);
      tbl[3]  = mk(0, 32'h0000, 1, 32'h100, 8'h00, 1, 0,  0, 0, 2'b01, 8'h00);
      tbl[4]  = mk(0, 32'h0000, 1, 32'h100, 8'h00, 1, 0,  0, 0, 2'b01, 8'h00);
      tbl[5]  = mk(1, 32'h0100, 0, 32'h000, 8'h00, 0, 0,  1, 1, 2'b11, 8'h00);
      tbl[6]  = mk(0, 32'h0000, 0, 32'h000, 8'h00, 0, 0,  0, 1, 2'b11, 8'h00);
      tbl[7]  = mk(1, 32'h0104, 1, 32'h100, 8'h00, 0, 0,  1, 1, 2'b10, 8'h01);
      tbl[8]  = mk(1, 32'h0104, 1, 32'h100, 8'h00, 0, 0,  1, 0, 2'b01, 8'h01);
      tbl[9]  = mk(1, 32'h010C, 1, 32'h100, 8'h00, 0, 0,  1, 0, 2'b00, 8'h03);
      tbl[10] = mk(1, 32'h0118, 1, 32'h100, 8'h00, 0, 0,  1, 0, 2'b00, 8'h06);
      tbl[11] = mk(0, 32'h0000, 0, 32'h000, 8'h00, 0, 0,  0, 0, 2'b00, 8'h06);
      tbl[12] = mk(0, 32'h0000, 1, 32'h200, 8'h02, 1, 1,  0, 0, 2'b00, 8'h06);
      tbl[13] = mk(1, 32'h0100, 0, 32'h000, 8'h00, 0, 0,  1, 0, 2'b01, 8'h05);
      tbl[14] = mk(1, 32'h0000, 1, 32'h000, 8'hA3, 1, 1,  1, 0, 2'b01, 8'h05);
      tbl[15] = mk(1, 32'h0000, 0, 32'h000, 8'h00, 0, 0,  1, 0, 2'b01, 8'h47);
      tbl[16] = mk(1, 32'h0000, 0, 32'h000, 8'hFF, 1, 1,  1, 0, 2'b01, 8'h8E);
      tbl[17] = mk(1, 32'h0000, 0, 32'h000, 8'h00, 0, 0,  1, 0, 2'b01, 8'h1C);
      tbl[18] = mk(1, 32'h0300, 1, 32'h300, 8'h38, 1, 0,  1, 1, 2'b10, 8'h38);
      tbl[19] = mk(0, 32'h0000, 0, 32'h000, 8'h00, 0, 0,  0, 1, 2'b10, 8'h38);
      // Same lookup through the bimodal instance reads pc index 0x40 (trained to 00) instead of 0x45.
      tbl[13].bm = 1'b1; tbl[13].bc = 2'b00; tbl[13].bg = 8'h05;

      cpu_rstn = 1'b1;
      #3 cpu_rstn = 1'b0;
      repeat (2) @(posedge cpu_clk);
      #1;
      chk_g("reset", 0, 1'b0, 1'b0, 2'b00, 8'h00);
      chk_w("reset", 0, 1'b0, 1'b0, 3'b000, 8'h00);
      cpu_rstn = 1'b1;

      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].req, tbl[i].pc, tbl[i].uv, tbl[i].upc, tbl[i].ughr, tbl[i].ut, tbl[i].um);
         chk_g("vec", i, tbl[i].ev, tbl[i].et, tbl[i].ec, tbl[i].eg);
         if (tbl[i].bm) begin
            chk("vec.b_valid", i, b_valid, 1'b1);
            chk("vec.b_cnt",   i, b_cnt,   tbl[i].bc);
            chk("vec.b_ghr",   i, b_ghr,   tbl[i].bg);
         end
      end

      // Asynchronous reset in the middle of a pending lookup and update.
      pred_req = 1; pred_pc = 32'h100; upd_valid = 1; upd_pc = 32'h100; upd_taken = 1;
      cpu_rstn = 1'b0;
      #1;
      chk_g("midrst", 0, 1'b0, 1'b0, 2'b00, 8'h00);
      chk_w("midrst", 0, 1'b0, 1'b0, 3'b000, 8'h00);
      drive(1, 32'h100, 1, 32'h100, 8'h00, 1, 0);
      chk_g("midrst", 1, 1'b0, 1'b0, 2'b00, 8'h00);
      cpu_rstn = 1'b1;

      // Write-first collision on a freshly reset entry, both counter widths.
      drive(1, 32'h100, 1, 32'h100, 8'h00, 1, 0);
      chk_g("bypass", 0, 1'b1, 1'b1, 2'b10, 8'h00);
      chk_w("bypass", 0, 1'b1, 1'b1, 3'b100, 8'h00);

      for (int i = 0; i < 4; i++) begin
         drive(0, 32'h0, 1, 32'h100, 8'h00, 1, 0);
         chk("sat.valid", i, g_valid, 1'b0);
      end
      // History became 0x01 after the taken prediction; pc 0x104 maps back onto entry 0x40.
      drive(1, 32'h104, 0, 32'h0, 8'h00, 0, 0);
      chk_g("sat", 0, 1'b1, 1'b1, 2'b11, 8'h01);
      chk_w("sat", 0, 1'b1, 1'b1, 3'b111, 8'h01);

      drive(0, 32'h0, 0, 32'h0, 8'h00, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
